transfer_n_to_simple_r: RTL and testbench
=========================================

// Module: transfer_n_to_simple_r
// PURPOSE
//  Feeds exactly N beats from a local data stream onto the R (read-data) channel of the simple AXI interface.
//  It is the read-side counterpart of the block that takes N beats off the simple W channel.
//  Sits between a unit datapath/buffer (data source) and the simple AXI slave read path.
//  A 2-entry skid buffer registers the outputs and sustains 1 beat/cycle under backpressure.
// PARAMETERS
//  AXI_DATA_W    32  width of data stream and m_rdata_o
//  MAX_TRANSF_W  32  width of beat counters / transferCount_i
// PORTS
//  clk_i               in   1             clock, all logic on rising edge
//  rst_i               in   1             reset; synchronous, active-high
//  transferCount_i     in   MAX_TRANSF_W  N, beats to send; sampled on initiateTransfer_i in IDLE
//  initiateTransfer_i  in   1             start pulse; ignored unless IDLE
//  busy_o              out  1             1 while not IDLE
//  done_o              out  1             1-cycle pulse when transfer completes
//  data_valid_i        in   1             source beat valid
//  data_i              in   AXI_DATA_W    source beat data
//  data_ready_o        out  1             source beat accepted when valid&&ready
//  m_rvalid_o          out  1             R channel valid
//  m_rready_i          in   1             R channel ready
//  m_rdata_o           out  AXI_DATA_W    R channel data
//  m_rlast_o           out  1             marks beat N
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state IDLE, counters 0, buffer empty; all outputs 0 the following cycle.
//  States: IDLE -> RUN on initiateTransfer_i with N>0; IDLE -> DONE on initiate with N=0;
//   RUN -> DONE on R handshake of beat N; DONE -> IDLE unconditionally (done_o=1 in DONE only).
//  Counters: acceptLeft (loaded N, dec on source handshake), sendLeft (loaded N, dec on R handshake).
//  data_ready_o = RUN && acceptLeft!=0 && buffer not full. Never accepts more than N beats.
//  Buffer: 2-entry FIFO; head drives m_rdata_o; m_rvalid_o = RUN && buffer not empty.
//  Latency: beat accepted in cycle t is presented on m_rvalid_o/m_rdata_o in cycle t+1 at earliest.
//  Throughput: 1 beat/cycle with source valid and sink ready continuously.
//  Simultaneous push+pop: occupancy unchanged, order preserved; push when full impossible (ready low).
//  Stall rule: while m_rvalid_o && !m_rready_i, m_rdata_o and m_rlast_o held stable.
//  m_rlast_o = m_rvalid_o && sendLeft==1. Outside RUN, m_rvalid_o/m_rlast_o/data_ready_o = 0 (the simple AXI
//   read side may pause between bursts; this block never asserts channel signals when not RUN).
//  Counters are MAX_TRANSF_W bits, unsigned, no wrap: decrement only when nonzero.
//  initiateTransfer_i while RUN/DONE: ignored, no reload.
//  Reset mid-RUN: buffer contents dropped, no done_o pulse.
// STRUCTURE
//  Shared Verilog header transfer_defs.vh: state encoding localparams (IDLE/RUN/DONE), reused by the
//   W-side transfer block.
//  Sub-module skid_buffer_2 (params DATA_W; ports clk_i, rst_i, in valid/ready/data, out valid/ready/data,
//   flush_i): the 2-entry register FIFO.
//  Top holds FSM and both counters.
// TESTING
//  N=4, source always valid (0xA0..0xA3), rready=1 -> rdata A0,A1,A2,A3 on 4 consecutive cycles;
//   rlast only on A3; done_o the cycle after; only 4 source handshakes.
//  N=1 -> single beat with m_rlast_o=1 on it; busy_o high 3 cycles total (RUN, DONE).
//  N=0 -> done_o the cycle after initiate; m_rvalid_o and data_ready_o never asserted.
//  N=8, rready pattern 1,0,1,0... -> rdata stable across stalls, data_ready_o drops once 2 beats are
//   buffered, all 8 beats in order.
//  Random stalls on both sides over N=100 -> scoreboard order/count exact, rlast on beat 100 only.
//  Start N=6, initiate N=5 mid-run (ignored); rst_i after 3 beats -> outputs 0 next cycle.
//   Then new N=2 completes normally.

Source files
------------

// File: rtl/transfer_n_to_simple_r_pkg.sv
// ----------------------------------------------------------------------------
// transfer_n_to_simple_r_pkg
//   Shared definitions for the N-beat transfer blocks on the simple AXI
//   interface. It holds the transfer FSM state encoding. The W-side transfer
//   block uses the same encoding, so both sides report the same
//   IDLE/RUN/DONE codes.
//   No ports (package).
// ----------------------------------------------------------------------------
package transfer_n_to_simple_r_pkg;

  // IDLE: waiting for a start pulse.
  // RUN:  moving beats.
  // DONE: one-cycle completion state that drives done_o.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } xfer_state_t;

endpackage : transfer_n_to_simple_r_pkg

// File: rtl/transfer_n_to_simple_r_skid.sv
// ----------------------------------------------------------------------------
// skid_buffer_2
//   Two-entry register FIFO between the local data source and the R channel.
//   The head entry drives out_data_o directly from a register. It can push
//   and pop in the same cycle, so it sustains one beat per cycle. It keeps
//   accepting one extra beat while the sink stalls.
// Ports
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous active-high reset
//   flush_i      in   1       synchronous clear of occupancy and data
//   in_valid_i   in   1       upstream beat valid
//   in_ready_o   out  1       room for a beat (occupancy < 2)
//   in_data_i    in   DATA_W  upstream beat data
//   out_valid_o  out  1       head entry present
//   out_ready_i  in   1       downstream accepts head
//   out_data_o   out  DATA_W  head entry data
// ----------------------------------------------------------------------------
module skid_buffer_2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic              w_push;
  logic              w_pop;

  // Handshake decode from occupancy.
  always_comb begin
    in_ready_o  = (r_count != 2'd2);
    out_valid_o = (r_count != 2'd0);
    out_data_o  = r_head;
    w_push      = in_valid_i && in_ready_o;
    w_pop       = out_valid_o && out_ready_i;
  end

  // Storage and occupancy update. The head always holds the oldest beat.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= in_data_i;
          end else begin
            r_tail <= in_data_i;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy stays the same. With one entry, the new beat becomes
          // the head. With two entries, the tail moves up to the head.
          if (r_count == 2'd1) begin
            r_head <= in_data_i;
          end else begin
            r_head <= r_tail;
            r_tail <= in_data_i;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule : skid_buffer_2

// File: rtl/transfer_n_to_simple_r.sv
// ----------------------------------------------------------------------------
// transfer_n_to_simple_r
//   Sends exactly N beats from a local data stream onto the R channel of the
//   simple AXI interface. A 2-entry skid buffer sits between the source and
//   the channel. The top holds the IDLE/RUN/DONE FSM and two counters:
//     - accept-left: counts beats still to take from the source.
//     - send-left:   counts beats still to hand to the R channel.
// Ports
//   clk_i               in   1             clock, rising edge
//   rst_i               in   1             synchronous active-high reset
//   transferCount_i     in   MAX_TRANSF_W  N, sampled on start in IDLE
//   initiateTransfer_i  in   1             start pulse, ignored unless IDLE
//   busy_o              out  1             high while not IDLE
//   done_o              out  1             one-cycle completion pulse
//   data_valid_i        in   1             source beat valid
//   data_i              in   AXI_DATA_W    source beat data
//   data_ready_o        out  1             source beat accepted on valid&&ready
//   m_rvalid_o          out  1             R channel valid
//   m_rready_i          in   1             R channel ready
//   m_rdata_o           out  AXI_DATA_W    R channel data
//   m_rlast_o           out  1             marks beat N
// ----------------------------------------------------------------------------
module transfer_n_to_simple_r
  import transfer_n_to_simple_r_pkg::*;
#(
  parameter int AXI_DATA_W   = 32,
  parameter int MAX_TRANSF_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [MAX_TRANSF_W-1:0] transferCount_i,
  input  logic                    initiateTransfer_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    data_valid_i,
  input  logic [AXI_DATA_W-1:0]   data_i,
  output logic                    data_ready_o,
  output logic                    m_rvalid_o,
  input  logic                    m_rready_i,
  output logic [AXI_DATA_W-1:0]   m_rdata_o,
  output logic                    m_rlast_o
);

  localparam logic [MAX_TRANSF_W-1:0] CNT_ONE = MAX_TRANSF_W'(1'b1);

  xfer_state_t             r_state;
  xfer_state_t             w_state_next;
  logic [MAX_TRANSF_W-1:0] r_accept_left;
  logic [MAX_TRANSF_W-1:0] r_send_left;

  logic                    w_running;
  logic                    w_start;
  logic                    w_src_valid;
  logic                    w_buf_in_ready;
  logic                    w_buf_out_valid;
  logic                    w_buf_out_ready;
  logic [AXI_DATA_W-1:0]   w_buf_data;
  logic                    w_src_fire;
  logic                    w_r_fire;
  logic                    w_last_beat;
  logic                    w_flush;

  // Handshake qualification shared by the FSM, the counters and the outputs.
  always_comb begin
    w_running       = (r_state == ST_RUN);
    w_start         = initiateTransfer_i && (r_state == ST_IDLE);
    // The source is only offered to the buffer while beats remain to be taken,
    // which caps acceptance at exactly N.
    w_src_valid     = data_valid_i && w_running && (r_accept_left != '0);
    w_src_fire      = w_src_valid && w_buf_in_ready;
    w_buf_out_ready = m_rready_i && w_running;
    w_r_fire        = w_buf_out_valid && w_buf_out_ready;
    w_last_beat     = (r_send_left == CNT_ONE);
    // The buffer is empty by DONE. Clearing it here also clears the head
    // register, so m_rdata_o does not keep stale data between transfers.
    w_flush         = (r_state == ST_DONE);
  end

  skid_buffer_2 #(
    .DATA_W (AXI_DATA_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (w_flush),
    .in_valid_i  (w_src_valid),
    .in_ready_o  (w_buf_in_ready),
    .in_data_i   (data_i),
    .out_valid_o (w_buf_out_valid),
    .out_ready_i (w_buf_out_ready),
    .out_data_o  (w_buf_data)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (transferCount_i == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RUN;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_r_fire && w_last_beat) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Beat counters. They load on start and decrement on their own handshake.
  // They saturate at zero and never wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_accept_left <= '0;
      r_send_left   <= '0;
    end else if (w_start) begin
      r_accept_left <= transferCount_i;
      r_send_left   <= transferCount_i;
    end else begin
      if (w_src_fire && (r_accept_left != '0)) begin
        r_accept_left <= r_accept_left - CNT_ONE;
      end else begin
        r_accept_left <= r_accept_left;
      end
      if (w_r_fire && (r_send_left != '0)) begin
        r_send_left <= r_send_left - CNT_ONE;
      end else begin
        r_send_left <= r_send_left;
      end
    end
  end

  // FSM and channel outputs. All of them decode registered state only.
  always_comb begin
    busy_o       = (r_state != ST_IDLE);
    done_o       = (r_state == ST_DONE);
    data_ready_o = w_running && (r_accept_left != '0) && w_buf_in_ready;
    m_rvalid_o   = w_running && w_buf_out_valid;
    m_rlast_o    = m_rvalid_o && w_last_beat;
    if (m_rvalid_o) begin
      m_rdata_o = w_buf_data;
    end else begin
      m_rdata_o = '0;
    end
  end

endmodule : transfer_n_to_simple_r

// File: tb/tb_transfer_n_to_simple_r.sv
// ----------------------------------------------------------------------------
// tb_transfer_n_to_simple_r
//   Directed self-checking bench for transfer_n_to_simple_r. Inputs change
//   1 time unit after the rising edge, and outputs are sampled at that same
//   point.
// ----------------------------------------------------------------------------
module tb_transfer_n_to_simple_r;

  logic        clk;
  logic        rst;
  logic [31:0] cnt;
  logic        init;
  logic        busy;
  logic        done;
  logic        dvalid;
  logic [31:0] din;
  logic        dready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rlast;

  int n_tests = 0;
  int n_fail  = 0;

  transfer_n_to_simple_r #(
    .AXI_DATA_W   (32),
    .MAX_TRANSF_W (32)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .transferCount_i    (cnt),
    .initiateTransfer_i (init),
    .busy_o             (busy),
    .done_o             (done),
    .data_valid_i       (dvalid),
    .data_i             (din),
    .data_ready_o       (dready),
    .m_rvalid_o         (rvalid),
    .m_rready_i         (rready),
    .m_rdata_o          (rdata),
    .m_rlast_o          (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
    check({tag, "_dready"}, 32'(dready), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_rlast"},  32'(rlast),  32'd0);
    check({tag, "_rdata"},  rdata,       32'd0);
  endtask

  // Runs one transfer of n beats. Source data is base+k.
  // Pattern 0 = always, 1 = alternate (sink starts ready), 2 = random.
  // exp_done is the expected loop cycle of done_o (-1: not checked).
  task automatic run_burst(input int n, input logic [31:0] base, input int src_pat,
                           input int snk_pat, input int exp_done, input bit exp_full,
                           input bit inj_init);
    int          src_idx = 0;
    int          beat = 0;
    int          done_cyc = -1;
    int          first_hs = -1;
    int          last_hs = -1;
    int          busy_cyc = 0;
    bit          saw_full = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;
    bit          src_hs;
    bit          r_hs;
    cnt    = 32'(n);
    init   = 1'b1;
    dvalid = 1'b0;
    rready = 1'b0;
    cycle();
    init = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (src_pat)
        0:       dvalid = 1'b1;
        1:       dvalid = cyc[0];
        default: dvalid = ($urandom_range(0, 3) != 0);
      endcase
      case (snk_pat)
        0:       rready = 1'b1;
        1:       rready = ~cyc[0];
        default: rready = ($urandom_range(0, 2) != 0);
      endcase
      din = base + 32'(src_idx);
      if (inj_init && cyc == 2) begin
        init = 1'b1;
        cnt  = 32'd2;
      end else begin
        init = 1'b0;
      end
      if (busy) busy_cyc++;
      if (src_idx >= n) check("no_extra_accept", 32'(dready), 32'd0);
      if (beat >= n)    check("no_extra_beat",   32'(rvalid), 32'd0);
      if (done) begin
        done_cyc = cyc;
        check("busy_in_done", 32'(busy), 32'd1);
        break;
      end
      if (rvalid) begin
        check("rdata_order", rdata, base + 32'(beat));
        check("rlast_beat", 32'(rlast), 32'(beat == n - 1));
      end else begin
        check("rlast_idle", 32'(rlast), 32'd0);
      end
      if (prev_stall) begin
        check("stall_rdata", rdata, prev_data);
        check("stall_rlast", 32'(rlast), 32'(prev_last));
      end
      if (!dready && src_idx < n && (src_idx - beat) == 2) saw_full = 1'b1;
      src_hs     = dvalid && dready;
      r_hs       = rvalid && rready;
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_last  = rlast;
      if (src_hs) src_idx++;
      if (r_hs) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        beat++;
      end
      cycle();
    end
    init   = 1'b0;
    dvalid = 1'b0;
    rready = 1'b0;
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    check("beat_count", 32'(beat), 32'(n));
    check("src_count", 32'(src_idx), 32'(n));
    check("busy_cycles", 32'(busy_cyc), 32'(done_cyc + 1));
    if (n > 0) check("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
    if (exp_done >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
    if (exp_full) check("ready_drop_full", 32'(saw_full), 32'd1);
    if (src_pat == 0 && snk_pat == 0 && n > 0)
      check("back_to_back", 32'(last_hs - first_hs), 32'(n - 1));
    cycle();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    int beat;
    int src_idx;
    rst    = 1'b1;
    cnt    = 32'd0;
    init   = 1'b0;
    dvalid = 1'b0;
    din    = 32'd0;
    rready = 1'b0;
    cycle();
    cycle();
    check_all_zero("reset");
    rst = 1'b0;
    cycle();
    check_all_zero("idle");

    // N=4, full throughput: A0..A3 back to back, done_o the cycle after A3.
    run_burst(4, 32'hA0, 0, 0, 5, 1'b0, 1'b0);
    // N=1: single beat with rlast; busy for 3 cycles.
    run_burst(1, 32'hB0, 0, 0, 2, 1'b0, 1'b0);
    // N=0: done_o immediately, no channel activity.
    run_burst(0, 32'hC0, 0, 0, 0, 1'b0, 1'b0);
    // N=8 with sink ready alternating: stalls hold data, buffer fills.
    run_burst(8, 32'h100, 0, 1, -1, 1'b1, 1'b0);
    // N=100 with random stalls on both sides.
    run_burst(100, 32'h1000, 2, 2, -1, 1'b0, 1'b0);
    // N=6 with a start pulse for N=2 mid-run: must still send 6.
    run_burst(6, 32'h200, 0, 0, 7, 1'b0, 1'b1);

    // N=6, reset after 3 beats, with outputs checked right after.
    beat    = 0;
    src_idx = 0;
    cnt     = 32'd6;
    init    = 1'b1;
    cycle();
    init = 1'b0;
    for (int cyc = 0; cyc < 20 && beat < 3; cyc++) begin
      dvalid = 1'b1;
      rready = 1'b1;
      din    = 32'h300 + 32'(src_idx);
      if (rvalid) check("rst_run_rdata", rdata, 32'h300 + 32'(beat));
      if (dvalid && dready) src_idx++;
      if (rvalid && rready) beat++;
      cycle();
    end
    check("rst_run_beats", 32'(beat), 32'd3);
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    dvalid = 1'b0;
    rready = 1'b0;
    check_all_zero("mid_reset");
    cycle();
    check("mid_reset_no_done", 32'(done), 32'd0);

    // Fresh N=2 after the reset completes normally.
    run_burst(2, 32'h400, 0, 0, 3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_transfer_n_to_simple_r
